// File: rtl/dummy_pkg.sv
// Shared types and helpers for the dummy round-robin controller.
package dummy_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } ctrl_state_e;

    // Width of a requester index; at least one bit
    function automatic int unsigned idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/dummy_rr_ctrl_if.sv
// Requester-side and shared-unit-side signal bundle of dummy_rr_ctrl.
// The slave modport is the controller; master is the requesters plus the unit.
interface dummy_rr_ctrl_if #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 32
);
    logic [NumReq-1:0]                req_i;
    logic [NumReq-1:0][DataWidth-1:0] data_i;
    logic [NumReq-1:0]                gnt_o;
    logic [NumReq-1:0]                rsp_valid_o;
    logic [DataWidth-1:0]             rsp_data_o;
    logic                             rsp_err_o;
    logic                             busy_o;
    logic                             sub_req_o;
    logic [DataWidth-1:0]             sub_data_o;
    logic                             sub_gnt_i;
    logic                             sub_rsp_valid_i;
    logic [DataWidth-1:0]             sub_rsp_data_i;

    modport slave (
        input  req_i, data_i, sub_gnt_i, sub_rsp_valid_i, sub_rsp_data_i,
        output gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o, sub_req_o, sub_data_o
    );

    modport master (
        output req_i, data_i, sub_gnt_i, sub_rsp_valid_i, sub_rsp_data_i,
        input  gnt_o, rsp_valid_o, rsp_data_o, rsp_err_o, busy_o, sub_req_o, sub_data_o
    );

endinterface

// File: rtl/dummy_rr_arb.sv
// Rotating-priority winner selection: first requester at or above the
// pointer, wrapping around. Purely combinational.
module dummy_rr_arb
    import dummy_pkg::*;
#(
    parameter int unsigned NumReq = 4,
    parameter int unsigned IdxW   = idx_width(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   ptr_i,
    output logic [NumReq-1:0] gnt_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    // Walk the requesters starting at the pointer and keep the first hit
    always_comb begin
        int unsigned      k;
        logic [IdxW-1:0]  k_idx;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        k     = 0;
        k_idx = '0;
        for (int unsigned i = 0; i < NumReq; i++) begin
            k     = (32'(ptr_i) + i) % NumReq;
            k_idx = IdxW'(k);
            if (!any_o && req_i[k_idx]) begin
                any_o        = 1'b1;
                gnt_o[k_idx] = 1'b1;
                idx_o        = k_idx;
            end
        end
    end

endmodule

// File: rtl/dummy_rr_ctrl.sv
// Round-robin controller sharing one processing unit between NumReq
// requesters: grant, issue to the unit, wait for its response, route it back.
// Optional watchdog in WAIT enabled by defining DUMMY_RR_CTRL_TIMEOUT_EN.
module dummy_rr_ctrl
    import dummy_pkg::*;
#(
    parameter int unsigned NumReq        = 4,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    dummy_rr_ctrl_if.slave bus
);

    localparam int unsigned IdxW = idx_width(NumReq);

    // Reject unusable configurations at elaboration
    if (NumReq < 2 || TimeoutCycles < 1) begin : g_cfg_check
        $error("dummy_rr_ctrl: NumReq must be >= 2 and TimeoutCycles >= 1");
    end

    ctrl_state_e          state_q;
    logic [IdxW-1:0]      ptr_q;
    logic [IdxW-1:0]      idx_q;
    logic [DataWidth-1:0] data_q;
    logic                 sub_req_q;
    logic                 busy_q;
    logic [NumReq-1:0]    rsp_valid_q;
    logic [DataWidth-1:0] rsp_data_q;

    logic [NumReq-1:0]    arb_gnt;
    logic [IdxW-1:0]      arb_idx;
    logic                 arb_any;

    dummy_rr_arb #(
        .NumReq (NumReq),
        .IdxW   (IdxW)
    ) u_arb (
        .req_i  (bus.req_i),
        .ptr_i  (ptr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx),
        .any_o  (arb_any)
    );

`ifdef DUMMY_RR_CTRL_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] cnt_q;
    logic            rsp_err_q;
`endif

    // Controller FSM with its registered outputs and latched transaction
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            data_q      <= '0;
            sub_req_q   <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
`ifdef DUMMY_RR_CTRL_TIMEOUT_EN
            cnt_q       <= '0;
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_any) begin
                        idx_q     <= arb_idx;
                        data_q    <= bus.data_i[arb_idx];
                        sub_req_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // A response strobe arriving here is deliberately dropped
                    if (bus.sub_gnt_i) begin
                        sub_req_q <= 1'b0;
                        state_q   <= WAIT;
`ifdef DUMMY_RR_CTRL_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                WAIT: begin
                    if (bus.sub_rsp_valid_i) begin
                        rsp_data_q  <= bus.sub_rsp_data_i;
                        rsp_valid_q <= NumReq'(1) << idx_q;
                        state_q     <= RESP;
`ifdef DUMMY_RR_CTRL_TIMEOUT_EN
                        rsp_err_q   <= 1'b0;
                    end else if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                        // Count reaches TimeoutCycles on this cycle: give up
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= NumReq'(1) << idx_q;
                        state_q     <= RESP;
                    end else begin
                        cnt_q       <= cnt_q + CntW'(1);
`endif
                    end
                end
                RESP: begin
                    rsp_valid_q <= '0;
                    busy_q      <= 1'b0;
                    ptr_q       <= (idx_q == IdxW'(NumReq - 1)) ? '0 : idx_q + IdxW'(1);
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Grant is combinational from the arbiter, only in IDLE and out of reset
    assign bus.gnt_o       = (rst_ni && state_q == IDLE) ? arb_gnt : '0;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_data_o  = rsp_data_q;
    assign bus.busy_o      = busy_q;
    assign bus.sub_req_o   = sub_req_q;
    assign bus.sub_data_o  = data_q;
`ifdef DUMMY_RR_CTRL_TIMEOUT_EN
    assign bus.rsp_err_o   = rsp_err_q;
`else
    assign bus.rsp_err_o   = 1'b0;
`endif

endmodule
